// File: rtl/his_pkg.sv
// Shared definitions for the histogram-equalization family of blocks.
// Provides the pixel width, the fixed median pipeline latency, the packed
// window-column type and a constant-evaluable ceil(log2) helper for sizing
// counters and RAM addresses.
package his_pkg;

  localparam int PIX_W       = 8;
  localparam int MED_LATENCY = 4;

  // One 3-high window column; index 0 = row y-2, 1 = row y-1, 2 = row y.
  typedef logic [2:0][PIX_W-1:0] col_t;

  // ceil(log2(n)), never less than 1 so a width is always legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/med3_sort.sv
// Three-input sorter with registered outputs.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   a, b, c        : unsigned pixel values
//   lo, mid, hi    : registered minimum, median and maximum of a, b, c
module med3_sort
  import his_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  output logic [PIX_W-1:0] lo,
  output logic [PIX_W-1:0] mid,
  output logic [PIX_W-1:0] hi
);

  logic [PIX_W-1:0] ab_lo, ab_hi;
  logic [PIX_W-1:0] lo_next, mid_next, hi_next;

  // Order a/b first, then place c against that pair.
  always_comb begin
    ab_lo    = (a < b) ? a : b;
    ab_hi    = (a < b) ? b : a;
    lo_next  = (c < ab_lo) ? c : ab_lo;
    hi_next  = (c > ab_hi) ? c : ab_hi;
    mid_next = (c < ab_lo) ? ab_lo : ((c > ab_hi) ? ab_hi : c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo  <= '0;
      mid <= '0;
      hi  <= '0;
    end else begin
      lo  <= lo_next;
      mid <= mid_next;
      hi  <= hi_next;
    end
  end

endmodule

// File: rtl/gray_median3x3.sv
// 3x3 median filter for the equalized gray stream.
// Two line buffers supply rows y-1 and y-2; three column registers form the
// window, and a pipelined sorting network produces the exact 5th-of-9 value.
// Sync signals and gray leave exactly MED_LATENCY clocks after they enter.
// The median for input (x,y) covers the window centered at (x-1,y-1).
// Ports:
//   clk, rst_n       : pixel clock, asynchronous active-low reset
//   median_en        : 1 = filter, 0 = pass-through (per pixel)
//   per_img_vsync    : input frame sync (rising edge starts a frame)
//   per_img_href     : input line valid
//   per_img_gray     : input gray pixel
//   post_img_vsync   : per_img_vsync delayed MED_LATENCY clocks
//   post_img_href    : per_img_href delayed MED_LATENCY clocks
//   post_img_gray    : filtered / passed pixel, 0 when post_img_href is low
module gray_median3x3
  import his_pkg::*;
#(
  parameter int IMG_WIDTH  = 800,
  parameter int IMG_HEIGHT = 600
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             median_en,
  input  logic             per_img_vsync,
  input  logic             per_img_href,
  input  logic [PIX_W-1:0] per_img_gray,
  output logic             post_img_vsync,
  output logic             post_img_href,
  output logic [PIX_W-1:0] post_img_gray
);

  localparam int XW = clog2(IMG_WIDTH);
  localparam int YW = clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  genvar gi;

  // ---------------------------------------------------------------- counters
  logic [XW-1:0] x_reg;
  logic          x_full_reg;     // set once column IMG_WIDTH-1 has been consumed
  logic [YW-1:0] y_reg;
  logic          href_prev_reg;
  logic          vsync_prev_reg;
  logic          pix_ok;
  logic          href_fall;
  logic          vsync_rise;
  logic          use_med;

  assign pix_ok     = per_img_href & ~x_full_reg;
  assign href_fall  = href_prev_reg & ~per_img_href;
  assign vsync_rise = per_img_vsync & ~vsync_prev_reg;
  assign use_med    = median_en & pix_ok & (x_reg >= XW'(2)) & (y_reg >= YW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg          <= '0;
      x_full_reg     <= 1'b0;
      y_reg          <= '0;
      href_prev_reg  <= 1'b0;
      vsync_prev_reg <= 1'b0;
    end else begin
      href_prev_reg  <= per_img_href;
      vsync_prev_reg <= per_img_vsync;
      // Holding x at 0 throughout blanking is equivalent to clearing it on
      // the falling edge, since x is only consumed while href is high.
      if (per_img_href) begin
        if (!x_full_reg) begin
          if (x_reg == X_LAST) x_full_reg <= 1'b1;
          else                 x_reg      <= x_reg + 1'b1;
        end
      end else begin
        x_reg      <= '0;
        x_full_reg <= 1'b0;
      end
      // Frame start outranks a coincident line end.
      if (vsync_rise)                          y_reg <= '0;
      else if (href_fall && (y_reg != Y_LAST)) y_reg <= y_reg + 1'b1;
    end
  end

  // ------------------------------------------------------------ line buffers
  logic [PIX_W-1:0] lb1_mem [IMG_WIDTH];
  logic [PIX_W-1:0] lb2_mem [IMG_WIDTH];
  logic [PIX_W-1:0] lb1_q;
  logic [PIX_W-1:0] lb2_q;
  logic             wr2_en_reg;
  logic [XW-1:0]    wr2_addr_reg;

  // LB1: registered read of the old value, then overwrite with the new pixel.
  always_ff @(posedge clk) begin
    if (pix_ok) begin
      lb1_q          <= lb1_mem[x_reg];
      lb1_mem[x_reg] <= per_img_gray;
    end
  end

  // LB2 takes LB1's old value one clock later, straight from LB1's read
  // register, so each RAM keeps a single read and a single write port.
  // The next pixel reads a different address, so the delay is invisible.
  always_ff @(posedge clk) begin
    if (pix_ok) lb2_q <= lb2_mem[x_reg];
    if (wr2_en_reg) lb2_mem[wr2_addr_reg] <= lb1_q;
  end

  // ------------------------------------------------------------------ window
  logic [PIX_W-1:0] pix_c1_reg;
  col_t             col0;
  col_t             col1_reg;
  col_t             col2_reg;

  // Newest column is the RAM read registers plus the registered pixel.
  assign col0 = {pix_c1_reg, lb1_q, lb2_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_c1_reg   <= '0;
      col1_reg     <= '0;
      col2_reg     <= '0;
      wr2_en_reg   <= 1'b0;
      wr2_addr_reg <= '0;
    end else begin
      wr2_en_reg   <= pix_ok;
      wr2_addr_reg <= x_reg;
      if (pix_ok) begin
        pix_c1_reg <= per_img_gray;
        col1_reg   <= col0;
        col2_reg   <= col1_reg;
      end
    end
  end

  // ---------------------------------------------------------- sorting network
  logic [PIX_W-1:0] row_lo  [3];
  logic [PIX_W-1:0] row_mid [3];
  logic [PIX_W-1:0] row_hi  [3];

  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      med3_sort u_row_sort (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (col2_reg[gi]),
        .b     (col1_reg[gi]),
        .c     (col0[gi]),
        .lo    (row_lo[gi]),
        .mid   (row_mid[gi]),
        .hi    (row_hi[gi])
      );
    end
  endgenerate

  // Median of 9 = med3(max of row mins, med of row meds, min of row maxes).
  logic [PIX_W-1:0] max_of_lo, med_of_mid, min_of_hi, med_q;
  logic [PIX_W-1:0] unused_s [8];

  med3_sort u_max_lo (
    .clk (clk), .rst_n (rst_n),
    .a (row_lo[0]), .b (row_lo[1]), .c (row_lo[2]),
    .lo (unused_s[0]), .mid (unused_s[1]), .hi (max_of_lo)
  );

  med3_sort u_med_mid (
    .clk (clk), .rst_n (rst_n),
    .a (row_mid[0]), .b (row_mid[1]), .c (row_mid[2]),
    .lo (unused_s[2]), .mid (med_of_mid), .hi (unused_s[3])
  );

  med3_sort u_min_hi (
    .clk (clk), .rst_n (rst_n),
    .a (row_hi[0]), .b (row_hi[1]), .c (row_hi[2]),
    .lo (min_of_hi), .mid (unused_s[4]), .hi (unused_s[5])
  );

  med3_sort u_final (
    .clk (clk), .rst_n (rst_n),
    .a (max_of_lo), .b (med_of_mid), .c (min_of_hi),
    .lo (unused_s[6]), .mid (med_q), .hi (unused_s[7])
  );

  // ------------------------------------------------------ sync / bypass delay
  logic [MED_LATENCY-1:0] vsync_dly_reg;
  logic [MED_LATENCY-1:0] href_dly_reg;
  logic [MED_LATENCY-1:0] med_dly_reg;
  logic [PIX_W-1:0]       pix_dly_reg [MED_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_dly_reg <= '0;
      href_dly_reg  <= '0;
      med_dly_reg   <= '0;
      for (int i = 0; i < MED_LATENCY; i++) pix_dly_reg[i] <= '0;
    end else begin
      vsync_dly_reg <= {vsync_dly_reg[MED_LATENCY-2:0], per_img_vsync};
      href_dly_reg  <= {href_dly_reg[MED_LATENCY-2:0], per_img_href};
      med_dly_reg   <= {med_dly_reg[MED_LATENCY-2:0], use_med};
      pix_dly_reg[0] <= per_img_gray;
      for (int i = 1; i < MED_LATENCY; i++) pix_dly_reg[i] <= pix_dly_reg[i-1];
    end
  end

  assign post_img_vsync = vsync_dly_reg[MED_LATENCY-1];
  assign post_img_href  = href_dly_reg[MED_LATENCY-1];

  // Final select is a plain mux on registered signals, so reset still
  // forces the output to 0 immediately.
  always_comb begin
    post_img_gray = '0;
    if (href_dly_reg[MED_LATENCY-1]) begin
      post_img_gray = med_dly_reg[MED_LATENCY-1] ? med_q : pix_dly_reg[MED_LATENCY-1];
    end
  end

endmodule

// File: doc/gray_median3x3.md
Name: gray_median3x3

Overview:
Post-processing stage placed directly downstream of the histogram-equalization top level. It consumes the equalized post_img_vsync/href/gray stream.
- Removes salt-and-pepper noise, which equalization amplifies, using a 3x3 median window built from two line buffers and a pipelined sorting network.
- Re-emits the stream with identical sync timing, delayed by a fixed latency, to the display/output path.

Parameters:
IMG_WIDTH, 800, active pixels per line; sizes line buffers and the column counter.
IMG_HEIGHT, 600, active lines per frame; sizes the row counter (800x600 = 480000 total pixels).

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
median_en  input  1  1 = median filtering, 0 = pass-through with the same latency; sampled per pixel
per_img_vsync  input  1  frame sync, active high; rising edge = frame start
per_img_href  input  1  line valid, active high; one pixel per clk while high
per_img_gray  input  8  equalized gray pixel
post_img_vsync  output  1  per_img_vsync delayed MED_LATENCY clks
post_img_href  output  1  per_img_href delayed MED_LATENCY clks
post_img_gray  output  8  filtered pixel, valid when post_img_href=1, else 0

Behaviour:
Reset
- All outputs 0.
- Counters, window registers, pipeline and sync delay lines cleared.
- Line-buffer RAM contents are not reset.

Latency
- MED_LATENCY = 4 clks, fixed, for vsync, href and gray alike.
- Pipeline: c1 line-buffer read + window shift; c2 per-row 3-sort; c3 max-of-mins / med-of-meds / min-of-maxes; c4 final 3-median, registered to output.

Counters
- col x: counts href-high pixels from 0; clears on href falling edge.
- row y: increments on href falling edge; clears on vsync rising edge.
- x saturates at IMG_WIDTH-1. Pixels beyond IMG_WIDTH are not written to the line buffers and are output pass-through.
- y saturates at IMG_HEIGHT-1.

Line buffers
- Two IMG_WIDTH x 8 RAMs, LB1 = row y-1 and LB2 = row y-2, addressed by x.
- On each href-high pixel: read LB1[x] and LB2[x], write LB2[x] <= LB1 old value, write LB1[x] <= new pixel. Read-before-write at the same address is required.

Window and output value
- Window = rows y-2..y, cols x-2..x, built from three column shift registers. The window is centered at (x-1, y-1).
- Output slot for input (x,y), with median_en=1 and x>=2 and y>=2: median of the window. This one-pixel diagonal shift is deliberate and documented.
- Otherwise (x<2, y<2, x>=IMG_WIDTH, or median_en=0): the input pixel (x,y) delayed MED_LATENCY clks.
- Median is exact order statistic 5 of 9; all comparisons are unsigned 8-bit; no arithmetic widening.

Boundary conditions
- href low: post_img_gray forced 0 in the matching output slot; no RAM write; window not advanced.
- vsync rising mid-frame: y cleared immediately; rows 0-1 of the new frame are pass-through. Stale line-buffer data is never used because y<2 gates it.
- Simultaneous vsync rise and href fall: the vsync clear wins, so y=0.
- rst_n asserted mid-frame: outputs drop to 0 asynchronously. After release, the first line seen is row 0 until the next vsync.
- median_en toggling mid-line takes effect on the very pixel sampled; there are no glitch-free requirements.

Decomposition:
Shared package his_pkg:
- PIX_W = 8
- MED_LATENCY = 4
- function clog2 for counter and address widths (also used by stat/proc blocks).

Sub-module med3_sort:
- Inputs: three 8-bit values. Outputs: registered min, med, max.
- Instantiated 3x in c2, and reused in c3/c4 taking only the needed outputs.

Test Plan:
(Use IMG_WIDTH=8, IMG_HEIGHT=6, one blanking clk between lines, unless stated.)
1. Reset while a frame is streaming -> post_img_* = 0 within the same clk; after release, a constant frame of 0x80 gives post gray 0x80 on every href slot, exactly 4 clks after the corresponding input.
2. Impulse: 0xFF at (3,3), all other pixels 0, median_en=1 -> every output slot = 0x00. Same impulse at (0,0) -> slot (0,0) = 0xFF (pass-through border).
3. Column ramp pixel = 10*x -> slot (x,y) with x>=2, y>=2 = 10*(x-1); slots with x<2 or y<2 = 10*x.
4. median_en=0 with random data -> post_img_gray equals per_img_gray delayed 4 clks bit-exactly; vsync/href delayed 4.
5. Line of 10 pixels (> IMG_WIDTH) -> pixels 8-9 pass through unchanged; the next line's window uses only x 0..7 data, with no corruption of line-buffer address 7.
6. vsync pulse after 3 lines, then a new frame with a checkerboard 0x00/0xFF -> new rows 0-1 pass-through; from row 2 the interior median matches the golden model, with no leakage of old-frame data.
